// File: rtl/sync_gated_decoder.sv
// sync_gated_decoder: registered, enable-gated SEL_W-to-2^SEL_W one-hot decoder
// with level, single-cycle pulse and timed-hold output modes. A timed strobe
// is accepted through a req/ready handshake and held for HOLD_CYCLES cycles.
module sync_gated_decoder #(
  parameter int SEL_W       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
  input  logic                    req,
  output logic                    ready,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic                    active
);

  localparam int N = 1 << SEL_W;

  // Mode encodings; 2'b11 is reserved and falls through to level behaviour.
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_TIMED = 2'b10;

  // The counter is loaded with HOLD_CYCLES-1 so that reaching zero marks the
  // last held cycle; the following edge releases y and returns to IDLE.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_next;
  logic [N-1:0]     r_y;
  logic [N-1:0]     w_y_next;
  logic             r_active;

  logic [N-1:0]     w_onehot_in;
  logic [N-1:0]     w_onehot_held;

  // Decode of the live select and of the select latched at acceptance.
  assign w_onehot_in   = N'(1) << sel;
  assign w_onehot_held = N'(1) << r_sel;

  // Next-state, next-output and counter logic for the IDLE/HOLD controller.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sel_next   = r_sel;
    w_y_next     = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (mode == MODE_PULSE) begin
          if (en && req) w_y_next = w_onehot_in;
        end else if (mode == MODE_TIMED) begin
          if (en && req) begin
            w_sel_next   = sel;
            w_y_next     = w_onehot_in;
            w_cnt_next   = HOLD_LOAD;
            w_state_next = ST_HOLD;
          end
        end else begin
          // Level mode and the reserved encoding.
          if (en) w_y_next = w_onehot_in;
        end
      end

      ST_HOLD: begin
        // sel, mode and req are ignored here; a dropped enable aborts at once.
        if (!en) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
          w_y_next   = w_onehot_held;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, counter, latched select and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_y      <= '0;
      r_active <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_sel    <= w_sel_next;
      r_y      <= w_y_next;
      r_active <= |w_y_next;
    end
  end

  // ready is a decode of registered state only, never of the current inputs.
  assign ready  = (r_state == ST_IDLE);
  assign y      = r_y;
  assign active = r_active;

endmodule
